// File: rtl/sif_rx_if.sv
// Serial receive link bundle: the 3-wire serial side (sck/sdat/sen) and the
// byte-wide valid/ready side with its error pulses.
// The slave modport is the receiver; the master modport is the peer that
// drives the serial lines and consumes bytes.
interface sif_rx_if;
    logic       sck;
    logic       sdat;
    logic       sen;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  sck,
        input  sdat,
        input  sen,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun
    );

    modport master (
        output sck,
        output sdat,
        output sen,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/sif_rx.sv
// 3-wire serial receiver (sck/sdat/sen, 8-bit, LSB first).
// All three lines pass through equal-depth synchronizers so their relative
// alignment is kept. Bits are sampled on synchronized sck rises while sen is
// high; the eighth bit hands the byte to a valid/ready holding register.
// Short or over-long frames raise frame_err, a byte arriving while the
// holding register is full and not being read raises overrun.
module sif_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic   clk,
    input  logic   rst,
    sif_rx_if.slave sif
);

    typedef enum logic [1:0] {
        IDLE_WAIT,
        IDLE,
        RECV
    } state_t;

    // Bit 0 of each chain is the raw line; bits 1..SYNC_STAGES are flops.
    logic [SYNC_STAGES:0] sck_chain;
    logic [SYNC_STAGES:0] sdat_chain;
    logic [SYNC_STAGES:0] sen_chain;

    logic       sck_s;
    logic       sdat_s;
    logic       sen_s;
    logic       sck_s_d;
    logic       sen_s_d;

    logic       sck_rise;
    logic       sen_rise;
    logic       sen_fall;
    logic       bit_take;
    logic       byte_done;
    logic [7:0] byte_next;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;

    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic       overrun_q;

    assign sck_chain[0]  = sif.sck;
    assign sdat_chain[0] = sif.sdat;
    assign sen_chain[0]  = sif.sen;

    assign sck_s  = sck_chain[SYNC_STAGES];
    assign sdat_s = sdat_chain[SYNC_STAGES];
    assign sen_s  = sen_chain[SYNC_STAGES];

    // Synchronizer chains plus one delayed copy of sck/sen for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_chain[SYNC_STAGES:1]  <= '0;
            sdat_chain[SYNC_STAGES:1] <= '0;
            sen_chain[SYNC_STAGES:1]  <= '0;
            sck_s_d                   <= 1'b0;
            sen_s_d                   <= 1'b0;
        end else begin
            sck_chain[SYNC_STAGES:1]  <= sck_chain[SYNC_STAGES-1:0];
            sdat_chain[SYNC_STAGES:1] <= sdat_chain[SYNC_STAGES-1:0];
            sen_chain[SYNC_STAGES:1]  <= sen_chain[SYNC_STAGES-1:0];
            sck_s_d                   <= sck_s;
            sen_s_d                   <= sen_s;
        end
    end

    assign sck_rise  = sck_s & ~sck_s_d;
    assign sen_rise  = sen_s & ~sen_s_d;
    assign sen_fall  = ~sen_s & sen_s_d;
    // A sck rise coinciding with sen falling is not a bit: sen_s is already 0.
    assign bit_take  = sck_rise & sen_s;
    assign byte_next = {sdat_s, shift[7:1]};
    assign byte_done = (state == RECV) && bit_take && (bit_cnt == 4'd7);

    // Frame state machine: bit sampling, bit counting and frame_err pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE_WAIT;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (bit_take) begin
                shift <= byte_next;
            end
            case (state)
                IDLE_WAIT: begin
                    if (!sen_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (sen_rise) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (sen_fall) begin
                        state       <= IDLE;
                        frame_err_q <= (bit_cnt != 4'd0) && (bit_cnt != 4'd8);
                    end else if (bit_take && (bit_cnt != 4'd9)) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE_WAIT;
                end
            endcase
        end
    end

    // Holding register: accept a completed byte, handshake, overrun pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (byte_done) begin
                if (!rx_valid_q || sif.rx_ready) begin
                    rx_data_q  <= byte_next;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && sif.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign sif.rx_data   = rx_data_q;
    assign sif.rx_valid  = rx_valid_q;
    assign sif.frame_err = frame_err_q;
    assign sif.overrun   = overrun_q;

endmodule

// File: doc/sif_rx.md
Name: sif_rx

Overview:
Serial-interface receiver; the downstream counterpart of the team's 3-wire serial transmitter (sck/sdat/sen, 8-bit, LSB first).
- Runs on the system clock and samples the three serial lines through synchronizer stages.
- Rebuilds each byte and presents it on a valid/ready output holding register.
- Flags short frames and overruns.
- Sits at the slave end of the serial link, in front of register-file or command-decode logic.

Parameters:
SYNC_STAGES, 2, synchronizer depth applied identically to sck, sdat and sen (legal 1..4).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
sck  input  1  serial clock from transmitter.
sdat  input  1  serial data, LSB first.
sen  input  1  frame enable, high for whole frame.
rx_data  output  8  received byte; valid while rx_valid=1.
rx_valid  output  1  byte available.
rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready at a clk edge.
frame_err  output  1  one-cycle pulse: frame ended with 1..7 bits or >8 bits.
overrun  output  1  one-cycle pulse: byte completed while holding register full and not being read.

Behaviour:
Reset and clocking:
- One clock, clk. Reset is asynchronous, active-low, on rst.
- On reset, all outputs are 0, all sync stages are 0, bit_cnt=0, shift=0, state=IDLE_WAIT.

Synchronization and edge detection:
- sck, sdat and sen each pass through a SYNC_STAGES-deep flop chain (sck_s, sdat_s, sen_s), plus one delayed copy of sck_s and sen_s for edge detection.
- sck_rise = sck_s & ~sck_s_d. sen_rise and sen_fall are defined the same way.
- Bit sample: on sck_rise while sen_s=1, shift register takes sdat_s, LSB first: shift <= {sdat_s, shift[7:1]}.

State machine:
- IDLE_WAIT: entered from reset. Moves to IDLE once sen_s=0 is seen. A line already high at reset release is ignored until it returns low, so no partial-frame error is raised.
- IDLE: on sen_rise go to RECV; bit_cnt=0.
- RECV:
  - Each qualified sck_rise increments bit_cnt, which saturates at 9 (9 means "too many").
  - When bit_cnt goes 7->8, the completed byte ({sdat_s, shift[7:1]}) goes to the holding logic in that same cycle.
  - On sen_fall go to IDLE. frame_err pulses if bit_cnt was 1..7 or 9; no pulse if 0 or 8.
  - If sen_fall and sck_rise arrive together, the edge is not counted (sen_s=0 disqualifies it).

Holding register and latency:
- Latency: if the 8th sck rise is first sampled at clk edge E0, rx_valid and rx_data update at edge E(SYNC_STAGES).
- Byte completion, case by case:
  - rx_valid=0: load rx_data, set rx_valid.
  - rx_valid=1 & rx_ready=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 & rx_ready=0: keep the old byte, drop the new one, pulse overrun for 1 cycle.
- Without a completion, rx_valid&rx_ready clears rx_valid. rx_data holds its last value.
- frame_err and overrun are registered single-cycle pulses and may coincide.

Mid-operation and back-to-back frames:
- Reset mid-frame discards the partial byte and any held byte. The frame in flight is never reported.
- Back-to-back frames are supported when sen is low for at least 1 clk after sync. A new sen_rise restarts bit_cnt; residual shift contents are irrelevant, since 8 fresh bits overwrite them.
- Input timing supported: the transmitter's fastest pattern, sck toggling every clk (one rise per 2 clk) with sdat changing with sck low-phase. Because all lines share an equal-depth sync chain, alignment is preserved.

Test Plan:
- Reset with sen=1 held, then frame 0xA5 (sen high, 8 rises, LSB first) after sen low for 3 clk -> no frame_err on the initial high; rx_data=0xA5, rx_valid=1 exactly SYNC_STAGES clks after the 8th rise is sampled.
- Frames 0x3C then 0xC3, rx_ready tied 1, sck toggling every clk, sen low 2 clk between frames -> two single-cycle rx_valid handshakes with 0x3C, 0xC3; no errors.
- Frame with 5 rises, then sen low -> frame_err pulses 1 cycle; rx_valid stays 0. Next 8-bit frame 0x81 -> rx_data=0x81 received cleanly.
- rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the 0x22 completion. Then rx_ready=1 with 0x33 completing in the same cycle -> rx_data=0x33, rx_valid stays 1, no overrun.
- Frame with 10 rises (bits 0x5A then 2 extra) -> rx_data=0x5A delivered at the 8th rise, frame_err pulses at sen fall.
- Assert rst low after 4 bits of a frame, release, then send 0xFF -> outputs 0 during reset, partial frame not reported, rx_data=0xFF received.
